clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable multi-channel clock-enable generator for the VGA/display subsystem and slow animation/timer logic. It is the successor to the fixed power-of-two divider. Each of CH channels divides clk_in by a runtime-loadable integer divisor, not only powers of two. Each channel produces a registered square-wave clk_out and a single-cycle tick strobe for use as a clock enable. Divisor changes are glitch-free: they take effect only at a period boundary. A global sync forces all channels into phase.

## Interface
- W, 18, width of divisor and per-channel counter (divisors 2 .. 2^W-1)
- CH, 2, number of independent channels
- DEFAULT_DIV, 2^(W-1), divisor loaded into every channel at reset (must be 2 .. 2^W-1)
- clk_in  input  1  system clock (50 MHz)
- rst  input  1  reset; synchronous, active-high
- en  input  CH  per-channel run enable
- sync  input  1  single-cycle pulse; forces a wrap on all enabled channels
- div_wr  input  1  write strobe for a new divisor
- div_sel  input  max(1,$clog2(CH))  target channel of div_wr; values >= CH are ignored
- div_val  input  W  new divisor; values 0 and 1 are clamped to 2
- div_busy  output  CH  channel has a pending divisor not yet applied
- clk_out  output  CH  registered divided clock, high floor(D/2) cycles, low ceil(D/2) cycles
- tick  output  CH  registered one-cycle pulse at the start of every period

## Operation
- Per-channel state:
  - cnt[W]: counter
  - act[W]: active divisor D
  - pend[W] and pend_v: pending divisor and its valid flag
- Reset values:
  - act = DEFAULT_DIV, cnt = DEFAULT_DIV-1
  - pend_v = 0, pend = 0
  - clk_out = 0, tick = 0, div_busy = 0
- Enabled channel, no sync:
  - If cnt == act-1 (wrap): cnt <= 0, tick <= 1, clk_out <= 1 (D >= 2 gives floor(D/2) >= 1).
    - If pend_v, then act <= pend and pend_v <= 0 on this same edge. The new D governs the period starting at cnt = 0.
  - Otherwise: cnt <= cnt+1, tick <= 0, clk_out <= (cnt+1 < act>>1).
- Disabled channel (en = 0):
  - cnt <= act'-1 ("primed"), clk_out <= 0, tick <= 0.
  - act' = pend if pend_v, else act. A pending divisor is applied on the next edge and pend_v clears.
  - The first enabled cycle therefore wraps: tick and clk_out rise together, and the first period is full length.
- sync (priority over normal counting): every enabled channel performs a forced wrap (cnt <= 0, tick <= 1, clk_out <= 1, pending applied) regardless of cnt. Disabled channels behave as disabled.
- Divisor write, when div_wr = 1 and div_sel < CH:
  - pend[div_sel] <= clamp(div_val) and pend_v <= 1.
  - A write while pend_v = 1 overwrites the pending value; the last write wins.
  - A write in the same cycle as a wrap/sync on that channel is NOT applied at that wrap. The old pend, if valid, is applied; the new value becomes pending for the following wrap.
- div_busy = pend_v (registered state, no combinational path from div_wr).
- Channels are fully independent apart from the shared sync and write bus.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Enabled steady state: tick period = D cycles; clk_out high for floor(D/2) cycles starting with the tick cycle.
- D = 2: clk_out toggles every cycle and tick is high every other cycle. D = 3: clk_out high 1 cycle, low 2 cycles.
- Latency:
  - en rising at edge k: tick = 1 after edge k+1.
  - sync sampled at edge k: tick = 1 after edge k.
  - div_wr at edge k: div_busy = 1 after edge k; cleared at the next wrap edge.
- Reset mid-period: all channels return to reset values on the next edge, pending writes are discarded, and outputs are 0 the cycle after rst is sampled.
- Counter never exceeds act-1. There is no overflow path; cnt+1 never wraps at W bits because act <= 2^W-1.

## Test plan
- Reset, then en = 1 with DEFAULT_DIV (W = 4, so D = 8): first tick 1 cycle after en; tick every 8 cycles; clk_out 4 high / 4 low.
- div_wr div_val = 5 mid-period on ch0: div_busy = 1 until the current 8-cycle period completes, then tick spacing = 5 and clk_out 2 high / 3 low. ch1 stays unaffected at D = 8.
- Writes of div_val = 0 and 1: both behave as D = 2 (tick every 2 cycles, clk_out alternates). A write with div_sel = CH (ch index out of range) changes nothing.
- Two writes (7 then 3) before a wrap: at the next wrap D = 3. A write of 6 coincident with a wrap edge takes effect one period later.
- Channels at cnt = 2 and cnt = 5, then sync pulse: both tick on the same edge and stay phase-aligned thereafter. A disabled channel produces no tick.
- rst asserted mid-period with a write pending: all outputs 0, div_busy = 0, and after release D = DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock-enable generator: each channel divides clk_in
// by a runtime-loadable divisor, with glitch-free divisor swaps and a global phase sync.

module clk_div_chan #(
  parameter int W           = 18,
  parameter int DEFAULT_DIV = 2**(W-1)
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_sync,
  input  logic         i_wr,
  input  logic [W-1:0] i_wval,
  output logic         o_busy,
  output logic         o_clk,
  output logic         o_tick
);
  localparam logic [W-1:0] DEF = W'(DEFAULT_DIV);

  logic [W-1:0] r_cnt, r_act, r_pend;
  logic         r_pend_v;
  logic [W-1:0] w_nxt_act, w_cnt_inc;
  logic         w_wrap;

  // Divisor that governs the next period if a boundary happens on this edge.
  assign w_nxt_act = r_pend_v ? r_pend : r_act;
  assign w_cnt_inc = r_cnt + W'(1);
  assign w_wrap    = i_sync || (r_cnt == r_act - W'(1));
  assign o_busy    = r_pend_v;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_act    <= DEF;
      r_cnt    <= DEF - W'(1);
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      o_clk    <= 1'b0;
      o_tick   <= 1'b0;
    end else begin
      if (!i_en) begin
        // Primed at the last count so the first enabled edge starts a full period.
        r_act    <= w_nxt_act;
        r_cnt    <= w_nxt_act - W'(1);
        r_pend_v <= 1'b0;
        o_clk    <= 1'b0;
        o_tick   <= 1'b0;
      end else if (w_wrap) begin
        r_act    <= w_nxt_act;
        r_cnt    <= '0;
        r_pend_v <= 1'b0;
        o_clk    <= 1'b1;
        o_tick   <= 1'b1;
      end else begin
        r_cnt    <= w_cnt_inc;
        o_clk    <= (w_cnt_inc < (r_act >> 1));
        o_tick   <= 1'b0;
      end
      // A write on a boundary edge lands after the swap above, so it waits a period.
      if (i_wr) begin
        r_pend   <= i_wval;
        r_pend_v <= 1'b1;
      end
    end
  end
endmodule

module clk_div_prog #(
  parameter int W           = 18,
  parameter int CH          = 2,
  parameter int DEFAULT_DIV = 2**(W-1),
  localparam int SW         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic [CH-1:0] en,
  input  logic          sync,
  input  logic          div_wr,
  input  logic [SW-1:0] div_sel,
  input  logic [W-1:0]  div_val,
  output logic [CH-1:0] div_busy,
  output logic [CH-1:0] clk_out,
  output logic [CH-1:0] tick
);
  logic [CH-1:0] w_wr;
  logic [W-1:0]  w_wval;

  assign w_wval = (div_val < W'(2)) ? W'(2) : div_val;

  // Selects >= CH match no channel and are dropped.
  for (genvar gi = 0; gi < CH; gi++) begin : g_dec
    assign w_wr[gi] = div_wr && (div_sel == SW'(gi));
  end

  clk_div_chan #(.W(W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch [CH-1:0] (
    .clk_in (clk_in),
    .rst    (rst),
    .i_en   (en),
    .i_sync (sync),
    .i_wr   (w_wr),
    .i_wval (w_wval),
    .o_busy (div_busy),
    .o_clk  (clk_out),
    .o_tick (tick)
  );
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with W=4 (default divisor 8) and three channels.

module tb_clk_div_prog;
  localparam int W  = 4;
  localparam int CH = 3;
  localparam int SW = 2;

  logic          clk_in = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic          sync;
  logic          div_wr;
  logic [SW-1:0] div_sel;
  logic [W-1:0]  div_val;
  logic [CH-1:0] div_busy, clk_out, tick;

  int vec = 0;
  int err = 0;

  clk_div_prog #(.W(W), .CH(CH), .DEFAULT_DIV(8)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync(sync), .div_wr(div_wr),
    .div_sel(div_sel), .div_val(div_val), .div_busy(div_busy),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input int sel, input int val);
    div_wr  = 1'b1;
    div_sel = SW'(sel);
    div_val = W'(val);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; sync = 1'b0; div_wr = 1'b0; div_sel = '0; div_val = '0;
    step(); step();
    vec++; if (tick !== 3'b000) begin err++; $display("FAIL reset_tick got %b exp 000", tick); end
    vec++; if (clk_out !== 3'b000) begin err++; $display("FAIL reset_clk got %b exp 000", clk_out); end
    vec++; if (div_busy !== 3'b000) begin err++; $display("FAIL reset_busy got %b exp 000", div_busy); end
    rst = 1'b0;
    step();
    vec++; if (tick !== 3'b000) begin err++; $display("FAIL idle_tick got %b exp 000", tick); end
  endtask

  task automatic test_default();
    logic t, c;
    en = 3'b011;
    for (int i = 0; i < 24; i++) begin
      step();
      t = (i % 8 == 0); c = (i % 8 < 4);
      vec++; if (tick !== {1'b0, t, t}) begin err++; $display("FAIL def_tick i=%0d got %b exp %b", i, tick, {1'b0, t, t}); end
      vec++; if (clk_out !== {1'b0, c, c}) begin err++; $display("FAIL def_clk i=%0d got %b exp %b", i, clk_out, {1'b0, c, c}); end
    end
  endtask

  task automatic test_div5();
    logic t0, c0, t1, c1;
    step();
    vec++; if (tick[1:0] !== 2'b11) begin err++; $display("FAIL d5_wrap got %b exp 11", tick[1:0]); end
    step(); step();
    wr(0, 5);
    step();
    div_wr = 1'b0;
    vec++; if (div_busy !== 3'b001) begin err++; $display("FAIL d5_busy_set got %b exp 001", div_busy); end
    for (int k = 4; k < 8; k++) begin
      step();
      vec++; if (div_busy !== 3'b001) begin err++; $display("FAIL d5_busy_hold k=%0d got %b exp 001", k, div_busy); end
    end
    for (int j = 0; j < 15; j++) begin
      step();
      t0 = (j % 5 == 0); c0 = (j % 5 < 2);
      t1 = (j % 8 == 0); c1 = (j % 8 < 4);
      vec++; if (tick[1:0] !== {t1, t0}) begin err++; $display("FAIL d5_tick j=%0d got %b exp %b", j, tick[1:0], {t1, t0}); end
      vec++; if (clk_out[1:0] !== {c1, c0}) begin err++; $display("FAIL d5_clk j=%0d got %b exp %b", j, clk_out[1:0], {c1, c0}); end
      vec++; if (div_busy !== 3'b000) begin err++; $display("FAIL d5_busy_clr j=%0d got %b exp 000", j, div_busy); end
    end
  endtask

  task automatic test_clamp();
    logic t;
    wr(2, 1);
    step();
    div_wr = 1'b0;
    vec++; if (div_busy[2] !== 1'b1) begin err++; $display("FAIL clamp1_busy got %b exp 1", div_busy[2]); end
    step();
    vec++; if (div_busy[2] !== 1'b0) begin err++; $display("FAIL clamp1_applied got %b exp 0", div_busy[2]); end
    en[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      t = (j % 2 == 0);
      vec++; if (tick[2] !== t) begin err++; $display("FAIL clamp1_tick j=%0d got %b exp %b", j, tick[2], t); end
      vec++; if (clk_out[2] !== t) begin err++; $display("FAIL clamp1_clk j=%0d got %b exp %b", j, clk_out[2], t); end
    end
    en[2] = 1'b0;
    wr(2, 9); step();
    div_wr = 1'b0; step();
    wr(2, 0); step();
    div_wr = 1'b0; step();
    vec++; if (tick[2] !== 1'b0 || clk_out[2] !== 1'b0) begin err++; $display("FAIL disabled_out got %b%b exp 00", tick[2], clk_out[2]); end
    en[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      t = (j % 2 == 0);
      vec++; if (tick[2] !== t) begin err++; $display("FAIL clamp0_tick j=%0d got %b exp %b", j, tick[2], t); end
      vec++; if (clk_out[2] !== t) begin err++; $display("FAIL clamp0_clk j=%0d got %b exp %b", j, clk_out[2], t); end
    end
    wr(3, 5);
    step();
    div_wr = 1'b0;
    vec++; if (div_busy !== 3'b000) begin err++; $display("FAIL oor_busy got %b exp 000", div_busy); end
    vec++; if (tick[2] !== 1'b1) begin err++; $display("FAIL oor_ch2_tick got %b exp 1", tick[2]); end
    step();
    vec++; if (tick[2] !== 1'b0) begin err++; $display("FAIL oor_ch2_tick2 got %b exp 0", tick[2]); end
  endtask

  task automatic test_back_to_back();
    logic t, c;
    sync = 1'b1;
    step();
    sync = 1'b0;
    vec++; if (tick !== 3'b111) begin err++; $display("FAIL b2b_sync got %b exp 111", tick); end
    wr(1, 7); step();
    wr(1, 3); step();
    div_wr = 1'b0;
    for (int k = 3; k < 8; k++) step();
    vec++; if (div_busy[1] !== 1'b1) begin err++; $display("FAIL b2b_busy got %b exp 1", div_busy[1]); end
    for (int j = 0; j < 6; j++) begin
      step();
      t = (j % 3 == 0);
      vec++; if (tick[1] !== t) begin err++; $display("FAIL b2b_d3_tick j=%0d got %b exp %b", j, tick[1], t); end
      vec++; if (clk_out[1] !== t) begin err++; $display("FAIL b2b_d3_clk j=%0d got %b exp %b", j, clk_out[1], t); end
      vec++; if (div_busy[1] !== 1'b0) begin err++; $display("FAIL b2b_d3_busy j=%0d got %b exp 0", j, div_busy[1]); end
    end
    wr(1, 6);
    step();
    div_wr = 1'b0;
    vec++; if (tick[1] !== 1'b1 || div_busy[1] !== 1'b1) begin err++; $display("FAIL coinc_wrap got tick=%b busy=%b exp 1 1", tick[1], div_busy[1]); end
    step(); step();
    vec++; if (tick[1] !== 1'b0 || div_busy[1] !== 1'b1) begin err++; $display("FAIL coinc_hold got tick=%b busy=%b exp 0 1", tick[1], div_busy[1]); end
    for (int j = 0; j < 12; j++) begin
      step();
      t = (j % 6 == 0); c = (j % 6 < 3);
      vec++; if (tick[1] !== t) begin err++; $display("FAIL coinc_d6_tick j=%0d got %b exp %b", j, tick[1], t); end
      vec++; if (clk_out[1] !== c) begin err++; $display("FAIL coinc_d6_clk j=%0d got %b exp %b", j, clk_out[1], c); end
    end
  endtask

  task automatic test_sync();
    logic t, c;
    en = 3'b000;
    step();
    wr(0, 8); step();
    wr(1, 8); step();
    div_wr = 1'b0; step();
    en = 3'b001;
    step(); step(); step();
    en = 3'b011;
    step(); step(); step();
    vec++; if (tick !== 3'b000) begin err++; $display("FAIL presync_tick got %b exp 000", tick); end
    sync = 1'b1;
    step();
    sync = 1'b0;
    vec++; if (tick !== 3'b011) begin err++; $display("FAIL sync_tick got %b exp 011", tick); end
    vec++; if (clk_out !== 3'b011) begin err++; $display("FAIL sync_clk got %b exp 011", clk_out); end
    for (int j = 1; j <= 16; j++) begin
      step();
      t = (j % 8 == 0); c = (j % 8 < 4);
      vec++; if (tick !== {1'b0, t, t}) begin err++; $display("FAIL sync_align_tick j=%0d got %b exp %b", j, tick, {1'b0, t, t}); end
      vec++; if (clk_out !== {1'b0, c, c}) begin err++; $display("FAIL sync_align_clk j=%0d got %b exp %b", j, clk_out, {1'b0, c, c}); end
    end
  endtask

  task automatic test_reset_mid();
    logic t, c;
    step(); step();
    wr(0, 3);
    step();
    div_wr = 1'b0;
    vec++; if (div_busy !== 3'b001) begin err++; $display("FAIL rstmid_busy got %b exp 001", div_busy); end
    rst = 1'b1;
    step();
    vec++; if (tick !== 3'b000) begin err++; $display("FAIL rstmid_tick got %b exp 000", tick); end
    vec++; if (clk_out !== 3'b000) begin err++; $display("FAIL rstmid_clk got %b exp 000", clk_out); end
    vec++; if (div_busy !== 3'b000) begin err++; $display("FAIL rstmid_busy_clr got %b exp 000", div_busy); end
    rst = 1'b0;
    for (int j = 0; j < 16; j++) begin
      step();
      t = (j % 8 == 0); c = (j % 8 < 4);
      vec++; if (tick !== {1'b0, t, t}) begin err++; $display("FAIL rstmid_d8_tick j=%0d got %b exp %b", j, tick, {1'b0, t, t}); end
      vec++; if (clk_out !== {1'b0, c, c}) begin err++; $display("FAIL rstmid_d8_clk j=%0d got %b exp %b", j, clk_out, {1'b0, c, c}); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_div5();
    test_clamp();
    test_back_to_back();
    test_sync();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
